// File: rtl/axil_gpio_irq.sv
// AXI4-Lite GPIO/LED slave for the XDMA BAR0 port with edge-detecting interrupt
// logic driving the usr_irq_req/usr_irq_ack handshake (one request per episode).
module axil_gpio_irq #(
   parameter logic [31:0] ID_VALUE = 32'h4750_4901,
   parameter int unsigned N_IO     = 4
) (
   input  logic            axi_aclk,
   input  logic            axi_areset,
   input  logic [8:0]      s_axil_awaddr,
   input  logic            s_axil_awvalid,
   output logic            s_axil_awready,
   input  logic [31:0]     s_axil_wdata,
   input  logic [3:0]      s_axil_wstrb,
   input  logic            s_axil_wvalid,
   output logic            s_axil_wready,
   output logic [1:0]      s_axil_bresp,
   output logic            s_axil_bvalid,
   input  logic            s_axil_bready,
   input  logic [8:0]      s_axil_araddr,
   input  logic            s_axil_arvalid,
   output logic            s_axil_arready,
   output logic [31:0]     s_axil_rdata,
   output logic [1:0]      s_axil_rresp,
   output logic            s_axil_rvalid,
   input  logic            s_axil_rready,
   output logic [2:0]      leds,
   input  logic [N_IO-1:0] iocon_i,
   output logic [N_IO-1:0] iocon_o,
   output logic [N_IO-1:0] iocon_t,
   output logic            usr_irq_req,
   input  logic            usr_irq_ack
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ARMED} irq_state_t;

   irq_state_t      r_state, w_state_nxt;
   logic            r_awready, r_bvalid, r_arready, r_rvalid;
   logic [31:0]     r_rdata, w_rdata;
   logic [2:0]      r_led;
   logic [N_IO-1:0] r_io_out, r_io_tri, r_stat, r_irq_en, r_edge_r, r_edge_f;
   logic            r_irq_gen;
   logic [N_IO-1:0] r_sync1, r_sync2, r_sync3, r_rise, r_fall;
   logic [N_IO-1:0] w_set, w_clr;
   logic            w_wr, w_rd, w_pending, w_irq_req, w_irq_wr;
   logic [6:0]      w_woff;
   logic            w_unused;

   assign w_wr     = r_awready & s_axil_awvalid & s_axil_wvalid;
   assign w_rd     = r_arready & s_axil_arvalid;
   assign w_woff   = s_axil_awaddr[8:2];
   assign w_irq_wr = w_wr & ((w_woff == 7'd4) | (w_woff == 7'd5));
   assign w_unused = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0], s_axil_wdata, s_axil_wstrb};

   // Edge pulses are registered once more, so STAT sets three edges after sampling.
   assign w_set     = (r_rise & r_edge_r) | (r_fall & r_edge_f);
   assign w_clr     = (w_wr && w_woff == 7'd4 && s_axil_wstrb[0]) ? s_axil_wdata[N_IO-1:0] : '0;
   assign w_pending = r_irq_gen & (|(r_stat & r_irq_en));

   always_comb begin
      w_rdata = '0;
      case (s_axil_araddr[8:2])
         7'd0: w_rdata[2:0]      = r_led;
         7'd1: w_rdata[N_IO-1:0] = r_io_out;
         7'd2: w_rdata[N_IO-1:0] = r_io_tri;
         7'd3: w_rdata[N_IO-1:0] = r_sync2;
         7'd4: w_rdata[N_IO-1:0] = r_stat;
         7'd5: begin
            w_rdata[31]        = r_irq_gen;
            w_rdata[N_IO-1:0]  = r_irq_en;
         end
         7'd6: begin
            w_rdata[N_IO-1:0]  = r_edge_r;
            w_rdata[N_IO+7:8]  = r_edge_f;
         end
         7'd7: w_rdata = ID_VALUE;
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_irq_req   = 1'b0;
      unique case (r_state)
         S_IDLE:  if (w_pending) w_state_nxt = S_REQ;
         S_REQ: begin
            w_irq_req = 1'b1;
            if (usr_irq_ack) w_state_nxt = S_ARMED;
         end
         S_ARMED: if (w_irq_wr) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         r_state   <= S_IDLE;
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_led     <= '0;
         r_io_out  <= '0;
         r_io_tri  <= '1;
         r_stat    <= '0;
         r_irq_en  <= '0;
         r_irq_gen <= 1'b0;
         r_edge_r  <= '0;
         r_edge_f  <= '0;
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_sync3   <= '0;
         r_rise    <= '0;
         r_fall    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_awready <= s_axil_awvalid & s_axil_wvalid & ~r_bvalid & ~r_awready;
         if (w_wr)               r_bvalid <= 1'b1;
         else if (s_axil_bready) r_bvalid <= 1'b0;

         r_arready <= s_axil_arvalid & ~r_rvalid & ~r_arready;
         if (w_rd) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
         end else if (s_axil_rready) begin
            r_rvalid <= 1'b0;
         end

         if (w_wr && s_axil_wstrb[0]) begin
            case (w_woff)
               7'd0: r_led    <= s_axil_wdata[2:0];
               7'd1: r_io_out <= s_axil_wdata[N_IO-1:0];
               7'd2: r_io_tri <= s_axil_wdata[N_IO-1:0];
               7'd5: r_irq_en <= s_axil_wdata[N_IO-1:0];
               7'd6: r_edge_r <= s_axil_wdata[N_IO-1:0];
               default: ;
            endcase
         end
         if (w_wr && s_axil_wstrb[1] && w_woff == 7'd6) r_edge_f  <= s_axil_wdata[N_IO+7:8];
         if (w_wr && s_axil_wstrb[3] && w_woff == 7'd5) r_irq_gen <= s_axil_wdata[31];

         r_stat  <= (r_stat & ~w_clr) | w_set;
         r_sync1 <= iocon_i;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_rise  <= r_sync2 & ~r_sync3;
         r_fall  <= ~r_sync2 & r_sync3;
      end
   end

   assign s_axil_awready = r_awready;
   assign s_axil_wready  = r_awready;
   assign s_axil_bvalid  = r_bvalid;
   assign s_axil_bresp   = 2'b00;
   assign s_axil_arready = r_arready;
   assign s_axil_rvalid  = r_rvalid;
   assign s_axil_rdata   = r_rdata;
   assign s_axil_rresp   = 2'b00;
   assign leds           = r_led;
   assign iocon_o        = r_io_out;
   assign iocon_t        = r_io_tri;
   assign usr_irq_req    = w_irq_req;

endmodule

// File: tb/tb_axil_gpio_irq.sv
// Self-checking bench for axil_gpio_irq: directed scenarios plus randomized
// register/pin/ack traffic checked against a transaction-level model.
module tb_axil_gpio_irq;
   localparam int unsigned N = 4;
   localparam logic [31:0] IDV = 32'h4750_4901;

   logic clk = 1'b0;
   logic rst;
   logic [8:0] awaddr, araddr;
   logic awvalid, awready, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0] wstrb;
   logic [1:0] bresp, rresp;
   logic [2:0] leds;
   logic [N-1:0] iocon_i, iocon_o, iocon_t;
   logic irq_req, irq_ack;

   always #5 clk = ~clk;

   axil_gpio_irq #(.ID_VALUE(IDV), .N_IO(N)) dut (
      .axi_aclk(clk), .axi_areset(rst),
      .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
      .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
      .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
      .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
      .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
      .leds(leds), .iocon_i(iocon_i), .iocon_o(iocon_o), .iocon_t(iocon_t),
      .usr_irq_req(irq_req), .usr_irq_ack(irq_ack)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference model: register contents, pin levels and interrupt episode status.
   logic [2:0]   m_led;
   logic [N-1:0] m_out, m_tri, m_stat, m_en, m_er, m_ef, m_pins;
   logic         m_gen, m_req, m_armed;

   task automatic m_reset;
      m_led = '0; m_out = '0; m_tri = '1; m_stat = '0; m_en = '0;
      m_er = '0; m_ef = '0; m_gen = 1'b0; m_req = 1'b0; m_armed = 1'b0;
   endtask

   function automatic logic [31:0] m_read(input logic [8:0] a);
      logic [31:0] v;
      v = '0;
      case (a[8:2])
         7'd0: v[2:0]   = m_led;
         7'd1: v[N-1:0] = m_out;
         7'd2: v[N-1:0] = m_tri;
         7'd3: v[N-1:0] = m_pins;
         7'd4: v[N-1:0] = m_stat;
         7'd5: begin v[31] = m_gen; v[N-1:0] = m_en; end
         7'd6: begin v[N-1:0] = m_er; v[N+7:8] = m_ef; end
         7'd7: v = IDV;
         default: v = '0;
      endcase
      return v;
   endfunction

   task automatic m_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
      int unsigned off;
      off = int'(a[8:2]);
      if (s[0]) begin
         if (off == 0) m_led = d[2:0];
         if (off == 1) m_out = d[N-1:0];
         if (off == 2) m_tri = d[N-1:0];
         if (off == 4) m_stat = m_stat & ~d[N-1:0];
         if (off == 5) m_en = d[N-1:0];
         if (off == 6) m_er = d[N-1:0];
      end
      if (s[1] && off == 6) m_ef = d[N+7:8];
      if (s[3] && off == 5) m_gen = d[31];
      if (off == 4 || off == 5) m_armed = 1'b0;
   endtask

   task automatic m_settle;
      if (!m_req && !m_armed && m_gen && |(m_stat & m_en)) m_req = 1'b1;
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, "_leds"}, 32'(leds), 32'(m_led));
      chk({tag, "_io_o"}, 32'(iocon_o), 32'(m_out));
      chk({tag, "_io_t"}, 32'(iocon_t), 32'(m_tri));
      chk({tag, "_req"}, 32'(irq_req), 32'(m_req));
   endtask

   task automatic axi_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
      int n;
      int pulses;
      pulses = 0;
      awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1;
      for (int i = 0; i < lead; i++) begin
         tick;
         if (awready || wready) pulses++;
      end
      awvalid = 1'b1;
      n = 0;
      while (!(awready && wready) && n < 20) begin
         tick;
         n++;
      end
      chk("aw_wait", 32'(n < 20), 32'd1);
      pulses++;
      tick;
      awvalid = 1'b0; wvalid = 1'b0;
      if (awready || wready) pulses++;
      chk("bvalid_rise", 32'(bvalid), 32'd1);
      chk("bresp", 32'(bresp), 32'd0);
      tick;
      if (awready || wready) pulses++;
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("aw_pulse", 32'(pulses), 32'd1);
      bready = 1'b1;
      tick;
      bready = 1'b0;
      chk("bvalid_drop", 32'(bvalid), 32'd0);
   endtask

   task automatic axi_rd(input logic [8:0] a, input logic [31:0] exp, input int hold);
      int n;
      araddr = a; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin
         tick;
         n++;
      end
      chk("ar_wait", 32'(n < 20), 32'd1);
      tick;
      arvalid = 1'b0;
      chk("rvalid", 32'(rvalid), 32'd1);
      chk($sformatf("rd_%03h", a), rdata, exp);
      chk("rresp", 32'(rresp), 32'd0);
      for (int i = 0; i < hold; i++) begin
         tick;
         chk("rdata_hold", rdata, exp);
      end
      rready = 1'b1;
      tick;
      rready = 1'b0;
      chk("rvalid_drop", 32'(rvalid), 32'd0);
   endtask

   task automatic do_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
      axi_wr(a, d, s, 0);
      m_write(a, d, s);
      repeat (6) tick;
      m_settle;
      chk_outs("wr");
   endtask

   task automatic do_rd(input logic [8:0] a, input int hold);
      axi_rd(a, m_read(a), hold);
   endtask

   task automatic pin_set(input logic [N-1:0] v);
      logic [N-1:0] rise, fall;
      rise = v & ~m_pins;
      fall = ~v & m_pins;
      m_stat = m_stat | (rise & m_er) | (fall & m_ef);
      m_pins = v;
      iocon_i = v;
      repeat (6) tick;
      m_settle;
      chk_outs("pin");
   endtask

   task automatic ack_pulse;
      irq_ack = 1'b1;
      tick;
      irq_ack = 1'b0;
      if (m_req) begin
         m_req = 1'b0;
         m_armed = 1'b1;
      end
      repeat (3) tick;
      m_settle;
      chk("ack_req", 32'(irq_req), 32'(m_req));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [8:0] a;
      int unsigned op, woff;
      logic [3:0] s;
      rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0; iocon_i = '0; irq_ack = 1'b0;
      m_reset;
      m_pins = '0;
      repeat (3) tick;
      rst = 1'b0;
      tick;

      // Reset state
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk_outs("rst");
      do_rd(9'h008, 0);
      do_rd(9'h01C, 0);

      // wvalid leads awvalid by two cycles
      axi_wr(9'h000, 32'h5, 4'hF, 2);
      m_write(9'h000, 32'h5, 4'hF);
      chk("led_101", 32'(leds), 32'h5);

      // Edge interrupt latency and request hold
      do_wr(9'h018, 32'h1, 4'hF);
      do_wr(9'h014, 32'h8000_0001, 4'hF);
      iocon_i = 4'h1;
      m_pins = 4'h1;
      m_stat = m_stat | 4'h1;
      repeat (4) tick;
      chk("req_lat_n3", 32'(irq_req), 32'd0);
      tick;
      chk("req_lat_n4", 32'(irq_req), 32'd1);
      m_req = 1'b1;
      do_rd(9'h010, 1);
      repeat (5) tick;
      chk("req_held", 32'(irq_req), 32'd1);
      ack_pulse;

      // Armed: new edges do not re-request
      pin_set(4'h0);
      pin_set(4'h1);
      pin_set(4'h0);

      // W1C of STAT lands on the same edge as a new rise: set wins
      iocon_i = 4'h1;
      m_pins = 4'h1;
      tick;
      tick;
      axi_wr(9'h010, 32'h1, 4'hF, 0);
      m_write(9'h010, 32'h1, 4'hF);
      m_stat = m_stat | 4'h1;
      repeat (4) tick;
      m_settle;
      chk("set_wins_req", 32'(irq_req), 32'd1);
      do_rd(9'h010, 0);

      // Pending drops while requesting: request stays until ack
      do_wr(9'h010, 32'h1, 4'hF);
      do_rd(9'h010, 0);

      // Byte strobes
      do_wr(9'h004, 32'hA, 4'h0);
      do_wr(9'h014, 32'h8000_0000, 4'h1);
      do_wr(9'h014, 32'h0000_0000, 4'h7);
      do_rd(9'h014, 0);
      do_wr(9'h018, 32'h0000_0F03, 4'h1);
      do_rd(9'h018, 0);

      // Reset with rvalid and usr_irq_req both high
      araddr = 9'h008; arvalid = 1'b1;
      tick;
      tick;
      arvalid = 1'b0;
      chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
      chk("pre_rst_req", 32'(irq_req), 32'd1);
      rst = 1'b1;
      tick;
      chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
      chk("rst_mid_req", 32'(irq_req), 32'd0);
      rst = 1'b0;
      m_reset;
      repeat (6) tick;
      chk_outs("post_rst");
      do_rd(9'h008, 0);
      do_rd(9'h014, 0);
      do_rd(9'h01C, 0);

      // Randomized traffic
      for (int it = 0; it < 120; it++) begin
         op = $urandom_range(0, 11);
         if (op <= 4) begin
            woff = $urandom_range(0, 9);
            a = (woff < 8) ? 9'(woff * 4) : ((woff == 8) ? 9'h020 : 9'h1FC);
            a[1:0] = 2'($urandom_range(0, 3));
            s = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            do_wr(a, $urandom, s);
         end else if (op <= 7) begin
            woff = $urandom_range(0, 9);
            a = (woff < 8) ? 9'(woff * 4) : ((woff == 8) ? 9'h040 : 9'h1F0);
            a[1:0] = 2'($urandom_range(0, 3));
            do_rd(a, int'($urandom_range(0, 2)));
         end else if (op <= 10) begin
            pin_set(m_pins ^ 4'($urandom_range(1, 15)));
         end else begin
            ack_pulse;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
